// File: rtl/prog_loader.sv
// prog_loader: framed byte-stream loader that writes 32-bit words to the
// instruction-memory flash port and holds the core in reset until a frame
// with a valid checksum has been loaded.
module prog_loader #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned MAX_WORDS = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       in_byte,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] flash_addr,
  output logic [WIDTH-1:0] flash_data,
  output logic             flash_en,
  output logic             cpu_rst,
  output logic             done,
  output logic             error
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_LO,
    S_CNT_HI,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [7:0]         cnt_lo_q;
  logic [CNT_W-1:0]   words_left_q;
  logic [1:0]         byte_idx_q;
  logic [23:0]        word_buf_q;
  logic [7:0]         sum_q;
  logic [WIDTH-1:0]   addr_cnt_q;

  logic               xfer_c;
  logic [CNT_W-1:0]   cnt_c;
  logic               word_last_c;
  logic               enter_cnt_c;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode and transfer strobes
  always_comb begin
    state_d     = state_q;
    xfer_c      = in_valid && in_ready;
    cnt_c       = {in_byte, cnt_lo_q};
    word_last_c = (byte_idx_q == 2'd3);
    enter_cnt_c = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) state_d = S_CNT_LO;
      end
      S_CNT_LO: begin
        if (xfer_c) state_d = S_CNT_HI;
      end
      S_CNT_HI: begin
        if (xfer_c) begin
          if (cnt_c > CNT_W'(MAX_WORDS)) state_d = S_ERROR;
          else if (cnt_c == '0)           state_d = S_CHECK;
          else                            state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer_c && word_last_c && (words_left_q == CNT_W'(1))) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (xfer_c) state_d = (in_byte == sum_q) ? S_DONE : S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase
    enter_cnt_c = (state_d == S_CNT_LO) && (state_q != S_CNT_LO);
  end

  // Registered status outputs follow the next state so they change with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready <= 1'b0;
      cpu_rst  <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      in_ready <= (state_d == S_CNT_LO) || (state_d == S_CNT_HI) ||
                  (state_d == S_DATA)   || (state_d == S_CHECK);
      cpu_rst  <= (state_d != S_DONE);
      done     <= (state_d == S_DONE);
      error    <= (state_d == S_ERROR);
    end
  end

  // Word assembly, checksum, address counter and flash write strike
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_lo_q     <= '0;
      words_left_q <= '0;
      byte_idx_q   <= '0;
      word_buf_q   <= '0;
      sum_q        <= '0;
      addr_cnt_q   <= '0;
      flash_addr   <= '0;
      flash_data   <= '0;
      flash_en     <= 1'b0;
    end else begin
      flash_en <= 1'b0;
      if (enter_cnt_c) begin
        addr_cnt_q <= '0;
        sum_q      <= '0;
        byte_idx_q <= '0;
      end
      if (xfer_c) begin
        case (state_q)
          S_CNT_LO: cnt_lo_q <= in_byte;
          S_CNT_HI: words_left_q <= cnt_c;
          S_DATA: begin
            sum_q      <= sum_q + in_byte;
            byte_idx_q <= byte_idx_q + 2'd1;
            case (byte_idx_q)
              2'd0:    word_buf_q[7:0]   <= in_byte;
              2'd1:    word_buf_q[15:8]  <= in_byte;
              2'd2:    word_buf_q[23:16] <= in_byte;
              default: begin
                flash_en     <= 1'b1;
                flash_data   <= WIDTH'({in_byte, word_buf_q});
                flash_addr   <= addr_cnt_q;
                addr_cnt_q   <= addr_cnt_q + WIDTH'(4);
                words_left_q <= words_left_q - CNT_W'(1);
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] flash_addr;
  logic [31:0] flash_data;
  logic        flash_en;
  logic        cpu_rst;
  logic        done;
  logic        error;

  int tests = 0;
  int fails = 0;

  logic [7:0]  frm[$];
  logic [63:0] wq[$];
  logic [31:0] nom_addr[3] = '{32'h0, 32'h4, 32'h8};
  logic [31:0] nom_data[3] = '{32'h00C64633, 32'h00160613, 32'hFFC00067};

  prog_loader #(.WIDTH(32), .MAX_WORDS(512)) dut (
    .clk(clk), .rst(rst), .start(start), .in_byte(in_byte),
    .in_valid(in_valid), .in_ready(in_ready), .flash_addr(flash_addr),
    .flash_data(flash_data), .flash_en(flash_en), .cpu_rst(cpu_rst),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Record every cycle in which flash_en is high
  always @(negedge clk) begin
    if (flash_en) wq.push_back({flash_addr, flash_data});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_frame(input bit throttle);
    foreach (frm[i]) begin
      if (throttle) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      in_byte  = frm[i];
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_byte  = 8'h00;
  endtask

  task automatic check_nominal_writes(input string tag);
    chk({tag, "_nwr"}, 32'(wq.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < wq.size()) begin
        chk({tag, "_addr"}, wq[i][63:32], nom_addr[i]);
        chk({tag, "_data"}, wq[i][31:0],  nom_data[i]);
      end
    end
  endtask

  task automatic set_nominal(input logic [7:0] ck);
    frm = '{8'h03, 8'h00, 8'h33, 8'h46, 8'hC6, 8'h00, 8'h13, 8'h06, 8'h16,
            8'h00, 8'h67, 8'h00, 8'hC0, 8'hFF};
    frm.push_back(ck);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_byte = 8'h00; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_flash_en", 32'(flash_en), 32'd0);
    chk("rst_addr", flash_addr, 32'h0);
    chk("rst_data", flash_data, 32'h0);
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd0);

    // Nominal load at full rate
    do_start();
    chk("start_in_ready", 32'(in_ready), 32'd1);
    wq.delete();
    set_nominal(8'h94);
    send_frame(1'b0);
    check_nominal_writes("nom");
    chk("nom_done", 32'(done), 32'd1);
    chk("nom_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("nom_in_ready", 32'(in_ready), 32'd0);
    chk("nom_error", 32'(error), 32'd0);

    // Bad checksum
    do_start();
    chk("bad_restart_done", 32'(done), 32'd0);
    wq.delete();
    set_nominal(8'h95);
    send_frame(1'b0);
    check_nominal_writes("bad");
    chk("bad_error", 32'(error), 32'd1);
    chk("bad_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("bad_done", 32'(done), 32'd0);

    // Empty frame
    do_start();
    chk("empty_restart_error", 32'(error), 32'd0);
    wq.delete();
    frm = '{8'h00, 8'h00, 8'h00};
    send_frame(1'b0);
    chk("empty_done", 32'(done), 32'd1);
    chk("empty_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("empty_nwr", 32'(wq.size()), 32'd0);

    // Over-count frame: error one cycle after the count high byte
    do_start();
    wq.delete();
    frm = '{8'h01, 8'h02};
    send_frame(1'b0);
    chk("ovr_error", 32'(error), 32'd1);
    chk("ovr_in_ready", 32'(in_ready), 32'd0);
    chk("ovr_cpu_rst", 32'(cpu_rst), 32'd1);
    repeat (3) @(negedge clk);
    chk("ovr_nwr", 32'(wq.size()), 32'd0);

    // Exactly MAX_WORDS is accepted: check the state advances into DATA
    do_start();
    frm = '{8'h00, 8'h02, 8'h00};
    send_frame(1'b0);
    chk("max_in_ready", 32'(in_ready), 32'd1);
    chk("max_error", 32'(error), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Throttled source
    do_start();
    wq.delete();
    set_nominal(8'h94);
    send_frame(1'b1);
    check_nominal_writes("thr");
    chk("thr_done", 32'(done), 32'd1);

    // Reset mid-word: two bytes into word 1
    do_start();
    wq.delete();
    frm = '{8'h03, 8'h00, 8'h33, 8'h46, 8'hC6, 8'h00, 8'h13, 8'h06};
    send_frame(1'b0);
    chk("mid_in_ready", 32'(in_ready), 32'd1);
    chk("mid_addr_w0", flash_addr, 32'h0);
    chk("mid_data_w0", flash_data, 32'h00C64633);
    #2 rst = 1'b1;
    #1;
    chk("mrst_in_ready", 32'(in_ready), 32'd0);
    chk("mrst_flash_en", 32'(flash_en), 32'd0);
    chk("mrst_addr", flash_addr, 32'h0);
    chk("mrst_data", flash_data, 32'h0);
    chk("mrst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_error", 32'(error), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_start();
    wq.delete();
    set_nominal(8'h94);
    send_frame(1'b0);
    check_nominal_writes("post");
    chk("post_done", 32'(done), 32'd1);

    // Reload after DONE
    do_start();
    chk("rel_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rel_done", 32'(done), 32'd0);
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    wq.delete();
    frm = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
    send_frame(1'b0);
    chk("rel_nwr", 32'(wq.size()), 32'd1);
    if (wq.size() > 0) begin
      chk("rel_addr", wq[0][63:32], 32'h0);
      chk("rel_data", wq[0][31:0], 32'h00000013);
    end
    chk("rel_done2", 32'(done), 32'd1);
    chk("rel_cpu_rst2", 32'(cpu_rst), 32'd0);

    // start is ignored mid-frame
    do_start();
    wq.delete();
    frm = '{8'h01, 8'h00, 8'h13};
    send_frame(1'b0);
    do_start();
    frm = '{8'h00, 8'h00, 8'h00, 8'h13};
    send_frame(1'b0);
    chk("ign_nwr", 32'(wq.size()), 32'd1);
    if (wq.size() > 0) chk("ign_data", wq[0][31:0], 32'h00000013);
    chk("ign_done", 32'(done), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
